// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake and shared full-adder hookup
// for serial_add_ctrl. The SUB field exists only when SERIAL_ADD_SUB_EN is
// defined. The slave modport is the controller's view; master is the
// requester / full-adder side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
`ifdef SERIAL_ADD_SUB_EN
  logic             SUB;
`endif
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             FA_X;
  logic             FA_Y;
  logic             FA_CPREV;
  logic             FA_RES;
  logic             FA_CNEXT;

`ifdef SERIAL_ADD_SUB_EN
  modport slave (
    input  START, A, B, CIN, SUB, FA_RES, FA_CNEXT,
    output BUSY, DONE, SUM, COUT, FA_X, FA_Y, FA_CPREV
  );
  modport master (
    output START, A, B, CIN, SUB, FA_RES, FA_CNEXT,
    input  BUSY, DONE, SUM, COUT, FA_X, FA_Y, FA_CPREV
  );
`else
  modport slave (
    input  START, A, B, CIN, FA_RES, FA_CNEXT,
    output BUSY, DONE, SUM, COUT, FA_X, FA_Y, FA_CPREV
  );
  modport master (
    output START, A, B, CIN, FA_RES, FA_CNEXT,
    input  BUSY, DONE, SUM, COUT, FA_X, FA_Y, FA_CPREV
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller driving an external shared
// full adder, LSB first. One bit is processed per clock, so a WIDTH-bit add
// takes WIDTH cycles in RUN followed by a single DONE cycle.
// Optional feature: define SERIAL_ADD_SUB_EN to add the SUB input, which
// turns the operation into A - B (B inverted, carry-in forced to 1).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            CLK,
  input  logic            RSTN,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign accept   = (state == S_IDLE) && bus.START;
  assign last_bit = (cnt == LAST_BIT);

  // Operand B and carry-in as captured on the accept edge
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = bus.SUB ? ~bus.B : bus.B;
  assign c_load = bus.SUB ? 1'b1   : bus.CIN;
`else
  assign b_load = bus.B;
  assign c_load = bus.CIN;
`endif

  // State register; reset aborts any operation in flight
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the combinational outputs derived from state
  always_comb begin
    state_nxt    = state;
    bus.BUSY     = 1'b0;
    bus.DONE     = 1'b0;
    bus.FA_X     = 1'b0;
    bus.FA_Y     = 1'b0;
    bus.FA_CPREV = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.START) state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.BUSY     = 1'b1;
        bus.FA_X     = a_sh[0];
        bus.FA_Y     = b_sh[0];
        bus.FA_CPREV = carry;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.DONE  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Serial datapath: load on accept, shift one bit per RUN cycle
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.A;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      sum_r <= {bus.FA_RES, sum_r[WIDTH-1:1]};
      carry <= bus.FA_CNEXT;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) cout_r <= bus.FA_CNEXT;
    end
  end

  assign bus.SUM  = sum_r;
  assign bus.COUT = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder on the
// FA_* ports and an arithmetic reference model of the add/subtract result.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RSTN;
  int   n_pass = 0;
  int   n_total = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural full adder
  assign bus.FA_RES   = bus.FA_X ^ bus.FA_Y ^ bus.FA_CPREV;
  assign bus.FA_CNEXT = (bus.FA_X & bus.FA_Y) | (bus.FA_X & bus.FA_CPREV) |
                        (bus.FA_Y & bus.FA_CPREV);

  // Reference result {cout, sum}
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    int r;
    if (sub) begin
      r = int'(a) - int'(b);
      return {(a >= b), 8'(r)};
    end
    r = int'(a) + int'(b) + int'(cin);
    return 9'(r);
  endfunction

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    bus.A   = a;
    bus.B   = b;
    bus.CIN = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.SUB = sub;
`else
    if (sub) bus.CIN = cin;
`endif
  endtask

  // Runs one operation and returns observations (no pass/fail decisions)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W-1:0] s, output logic c,
                        output int busy_n, output int done_at, output int fa_err);
    int beff;
    int ceff;
    int k;
    int m;
    logic ex, ey, ec;
    busy_n = 0; done_at = -1; fa_err = 0; s = 'x; c = 1'bx;
    beff = sub ? int'(~b) & 32'hFF : int'(b);
    ceff = sub ? 1 : int'(cin);
    @(negedge CLK);
    bus.START = 1'b1;
    drive_ops(a, b, cin, sub);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin
        bus.START = 1'b0;
        drive_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      if (bus.BUSY === 1'b1) busy_n++;
      if (cyc <= W) begin
        k  = cyc - 1;
        m  = (1 << k) - 1;
        ex = a[k];
        ey = beff[k];
        ec = 1'(((int'(a) & m) + (beff & m) + ceff) >> k);
      end else begin
        ex = 1'b0; ey = 1'b0; ec = 1'b0;
      end
      if (bus.FA_X !== ex || bus.FA_Y !== ey || bus.FA_CPREV !== ec) fa_err++;
      if (bus.DONE === 1'b1) begin
        done_at = cyc;
        s = bus.SUM;
        c = bus.COUT;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    bus.START = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.BUSY); else n_pass++;
    n_total++; if (bus.DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.DONE); else n_pass++;
    n_total++; if (bus.SUM !== 8'h00) $display("FAIL reset_sum got=%h exp=00", bus.SUM); else n_pass++;
    n_total++; if (bus.COUT !== 1'b0) $display("FAIL reset_cout got=%b exp=0", bus.COUT); else n_pass++;
    n_total++;
    if ({bus.FA_X, bus.FA_Y, bus.FA_CPREV} !== 3'b000)
      $display("FAIL reset_fa got=%b exp=000", {bus.FA_X, bus.FA_Y, bus.FA_CPREV});
    else n_pass++;
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++; if (bus.BUSY !== 1'b0) $display("FAIL idle_busy got=%b exp=0", bus.BUSY); else n_pass++;
  endtask

  task automatic test_directed;
    logic [W-1:0] av [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] bv [3] = '{8'h3C, 8'h01, 8'hFF};
    logic         cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] s;
    logic         c;
    logic [W:0]   exp;
    int           bn, da, fe;
    cv[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], cv[i], 1'b0, s, c, bn, da, fe);
      exp = ref_op(av[i], bv[i], cv[i], 1'b0);
      n_total++; if (bn !== W) $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bn, W); else n_pass++;
      n_total++; if (da !== W + 1) $display("FAIL dir%0d_done_cycle got=%0d exp=%0d", i, da, W + 1); else n_pass++;
      n_total++; if (s !== exp[W-1:0]) $display("FAIL dir%0d_sum got=%h exp=%h", i, s, exp[W-1:0]); else n_pass++;
      n_total++; if (c !== exp[W]) $display("FAIL dir%0d_cout got=%b exp=%b", i, c, exp[W]); else n_pass++;
      n_total++; if (fe !== 0) $display("FAIL dir%0d_fa_ports errors=%0d exp=0", i, fe); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, s;
    logic         ci, c;
    logic [W:0]   exp;
    int           bn, da, fe;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      run_op(a, b, ci, 1'b0, s, c, bn, da, fe);
      exp = ref_op(a, b, ci, 1'b0);
      n_total++;
      if (da !== W + 1 || bn !== W)
        $display("FAIL rnd%0d_latency done_at=%0d busy=%0d exp=%0d/%0d", i, da, bn, W + 1, W);
      else n_pass++;
      n_total++;
      if ({c, s} !== exp) $display("FAIL rnd%0d_result a=%h b=%h cin=%b got=%h exp=%h", i, a, b, ci, {c, s}, exp);
      else n_pass++;
      n_total++; if (fe !== 0) $display("FAIL rnd%0d_fa_ports errors=%0d exp=0", i, fe); else n_pass++;
    end
  endtask

  task automatic test_hold;
    logic [W-1:0] s;
    logic         c;
    logic [W:0]   exp;
    int           bn, da, fe;
    run_op(8'hC3, 8'h5E, 1'b1, 1'b0, s, c, bn, da, fe);
    exp = ref_op(8'hC3, 8'h5E, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      n_total++;
      if ({bus.COUT, bus.SUM} !== exp || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0)
        $display("FAIL hold%0d got=%h done=%b busy=%b exp=%h/0/0", i, {bus.COUT, bus.SUM}, bus.DONE, bus.BUSY, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] oa [30];
    logic [W-1:0] ob [30];
    logic         oc [30];
    logic [W:0]   exp;
    logic         eb, ed;
    @(negedge CLK);
    oa[0] = 8'($urandom); ob[0] = 8'($urandom); oc[0] = 1'($urandom);
    bus.START = 1'b1;
    drive_ops(oa[0], ob[0], oc[0], 1'b0);
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(negedge CLK);
      ed = (cyc % 10 == 9);
      eb = (cyc % 10 >= 1) && (cyc % 10 <= 8);
      n_total++;
      if (bus.DONE !== ed || bus.BUSY !== eb)
        $display("FAIL b2b_cyc%0d done=%b busy=%b exp=%b/%b", cyc, bus.DONE, bus.BUSY, ed, eb);
      else n_pass++;
      if (ed) begin
        exp = ref_op(oa[cyc-9], ob[cyc-9], oc[cyc-9], 1'b0);
        n_total++;
        if ({bus.COUT, bus.SUM} !== exp)
          $display("FAIL b2b_result_cyc%0d got=%h exp=%h", cyc, {bus.COUT, bus.SUM}, exp);
        else n_pass++;
      end
      oa[cyc] = 8'($urandom); ob[cyc] = 8'($urandom); oc[cyc] = 1'($urandom);
      drive_ops(oa[cyc], ob[cyc], oc[cyc], 1'b0);
      if (cyc == 29) bus.START = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] s;
    logic         c;
    int           bn, da, fe, dn;
    @(negedge CLK);
    bus.START = 1'b1;
    drive_ops(8'hAA, 8'h77, 1'b1, 1'b0);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    n_total++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
      $display("FAIL abort_ctrl busy=%b done=%b exp=0/0", bus.BUSY, bus.DONE);
    else n_pass++;
    n_total++;
    if ({bus.COUT, bus.SUM} !== 9'h000) $display("FAIL abort_result got=%h exp=000", {bus.COUT, bus.SUM});
    else n_pass++;
    @(negedge CLK);
    RSTN = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) dn++;
    end
    n_total++; if (dn !== 0) $display("FAIL abort_no_done activity_cycles=%0d exp=0", dn); else n_pass++;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, s, c, bn, da, fe);
    n_total++;
    if ({c, s} !== 9'h003 || da !== W + 1)
      $display("FAIL after_abort got=%h done_at=%0d exp=003/%0d", {c, s}, da, W + 1);
    else n_pass++;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    logic [W-1:0] a, b, s;
    logic         c;
    logic [W:0]   exp;
    int           bn, da, fe;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin a = 8'h10; b = 8'h01; end
      else if (i == 1) begin a = 8'h01; b = 8'h02; end
      else begin a = 8'($urandom); b = 8'($urandom); end
      run_op(a, b, 1'($urandom), 1'b1, s, c, bn, da, fe);
      exp = ref_op(a, b, 1'b0, 1'b1);
      n_total++;
      if ({c, s} !== exp || da !== W + 1)
        $display("FAIL sub%0d a=%h b=%h got=%h done_at=%0d exp=%h", i, a, b, {c, s}, da, exp);
      else n_pass++;
      n_total++; if (fe !== 0) $display("FAIL sub%0d_fa_ports errors=%0d exp=0", i, fe); else n_pass++;
    end
  endtask
`endif

  initial begin
    bus.START = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
